cdb_arbiter: RTL and testbench

Arbiter that shares the three common data buses (cdb1..cdb3) among the execution units' result ports. Each requester hands over one 38-bit result (6-bit tag + 32-bit data) per cycle via valid/ready. The block buffers one result per requester and grants up to three pending results per cycle, round-robin. The granted results drive registered CDB outputs consumed by the reservation stations and reorder logic.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 41 ++++
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// ============================================================================
// cdb_pkg : common data bus types and widths shared with the RS and ROB
// Revision: 1.0
// ============================================================================
`default_nettype none

package cdb_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int CDB_W  = TAG_W + DATA_W;
  localparam int N_CDB  = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  // Tag 0 is reserved, so an all-zero bus means "no broadcast".
  localparam cdb_t CDB_IDLE = '0;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// rr_picker : first set bit of a pending mask, scanning upward from a start
//             index with wraparound; returns one-hot, index and found flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int               w_sum;
    logic [IDX_W-1:0] w_j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    w_sum  = 0;
    w_j    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(start) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_j = w_sum[IDX_W-1:0];
      if (!found && pending[w_j]) begin
        found       = 1'b1;
        onehot[w_j] = 1'b1;
        idx         = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : buffers one result per requester and grants up to three per
//               cycle, round-robin, onto the registered cdb1..cdb3 outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   kill,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CDB_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [CDB_W-1:0]       cdb1,
  output logic [CDB_W-1:0]       cdb2,
  output logic [CDB_W-1:0]       cdb3
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] r_buf_valid;
  cdb_t             r_buf_data [N_REQ];
  logic [IDX_W-1:0] r_rr_ptr;
  cdb_t             r_cdb [N_CDB];

  logic [N_REQ-1:0] w_pend   [N_CDB];
  logic [N_REQ-1:0] w_onehot [N_CDB];
  logic [IDX_W-1:0] w_idx    [N_CDB];
  logic [N_CDB-1:0] w_found;
  logic [N_REQ-1:0] w_grant;
  logic [N_REQ-1:0] w_xfer;
  logic [IDX_W-1:0] w_last;
  logic [IDX_W-1:0] w_next_ptr;
  cdb_t             w_bus [N_CDB];

  // Each stage scans from the same pointer; masking earlier winners keeps
  // the three grants in scan order.
  for (genvar s = 0; s < N_CDB; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign w_pend[s] = r_buf_valid;
    end else begin : g_next
      assign w_pend[s] = w_pend[s-1] & ~w_onehot[s-1];
    end

    rr_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
    ) u_pick (
      .pending (w_pend[s]),
      .start   (r_rr_ptr),
      .onehot  (w_onehot[s]),
      .idx     (w_idx[s]),
      .found   (w_found[s])
    );

    assign w_bus[s] = w_found[s] ? r_buf_data[w_idx[s]] : CDB_IDLE;
  end

  always_comb begin
    w_grant = '0;
    w_last  = '0;
    for (int s = 0; s < N_CDB; s++) begin
      w_grant = w_grant | w_onehot[s];
      if (w_found[s]) w_last = w_idx[s];
    end
  end

  assign w_next_ptr = (w_last == IDX_W'(N_REQ - 1)) ? '0 : w_last + 1'b1;
  assign req_ready  = ~r_buf_valid | w_grant;
  assign w_xfer     = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_valid <= '0;
      r_rr_ptr    <= '0;
      for (int s = 0; s < N_CDB; s++) r_cdb[s] <= CDB_IDLE;
    end else if (kill) begin
      r_buf_valid <= '0;
      for (int s = 0; s < N_CDB; s++) r_cdb[s] <= CDB_IDLE;
    end else begin
      r_buf_valid <= (r_buf_valid & ~w_grant) | w_xfer;
      for (int s = 0; s < N_CDB; s++) r_cdb[s] <= w_bus[s];
      if (|w_found) r_rr_ptr <= w_next_ptr;
    end
  end

  // Payload needs no reset: it is only observed behind r_buf_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_xfer[i]) r_buf_data[i] <= cdb_t'(req_data[i*CDB_W +: CDB_W]);
    end
  end

  assign cdb1 = r_cdb[0];
  assign cdb2 = r_cdb[1];
  assign cdb3 = r_cdb[2];

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter (N_REQ = 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  logic         clk;
  logic         reset;
  logic         kill;
  logic [3:0]   req_valid;
  logic [151:0] req_data;
  logic [3:0]   req_ready;
  logic [37:0]  cdb1;
  logic [37:0]  cdb2;
  logic [37:0]  cdb3;

  int n_vec;
  int n_err;

  cdb_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb1      (cdb1),
    .cdb2      (cdb2),
    .cdb3      (cdb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] res(input int tag);
    logic [5:0] t;
    t = tag[5:0];
    return {t, 8'hA5, 18'h0, t};
  endfunction

  task automatic set_slot(input int i, input logic [37:0] v);
    req_data[38*i +: 38] = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] mask, input int base);
    for (int i = 0; i < 4; i++) set_slot(i, res(base + i));
    req_valid = mask;
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset;
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL reset_cdb: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
    n_vec++;
    if (req_ready !== 4'b1111) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1111", req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_slot(i, res(1 + i));
    req_valid = 4'b1111;
    tick();
    n_vec++;
    if (req_ready !== 4'b0111) begin
      n_err++; $display("FAIL fill_ready: got %b expected 0111", req_ready);
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(1), res(2), res(3)}) begin
      n_err++; $display("FAIL fill_cdb: got %h %h %h expected %h %h %h", cdb1, cdb2, cdb3, res(1), res(2), res(3));
    end
    #3;
    reset = 1'b1;
    req_valid = '0;
    #1;
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL async_reset_cdb: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
    n_vec++;
    if (req_ready !== 4'b1111) begin
      n_err++; $display("FAIL async_reset_ready: got %b expected 1111", req_ready);
    end
    #1;
    reset = 1'b0;
    push(4'b1001, 40);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(40), res(43), 38'b0}) begin
      n_err++; $display("FAIL reset_ptr: got %h %h %h expected %h %h 0", cdb1, cdb2, cdb3, res(40), res(43));
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL reset_drain: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
  endtask

  task automatic test_single;
    set_slot(2, {6'd5, 32'hDEADBEEF});
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL single_latency: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {6'd5, 32'hDEADBEEF, 76'b0}) begin
      n_err++; $display("FAIL single_bcast: got %h %h %h expected 05deadbeef 0 0", cdb1, cdb2, cdb3);
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL single_once: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
  endtask

  task automatic test_oversub;
    push(4'b1000, 50);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(53), 76'b0}) begin
      n_err++; $display("FAIL oversub_setup: got %h %h %h expected %h 0 0", cdb1, cdb2, cdb3, res(53));
    end
    push(4'b1111, 60);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(60), res(61), res(62)}) begin
      n_err++; $display("FAIL oversub_first: got %h %h %h expected %h %h %h", cdb1, cdb2, cdb3, res(60), res(61), res(62));
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(63), 76'b0}) begin
      n_err++; $display("FAIL oversub_second: got %h %h %h expected %h 0 0", cdb1, cdb2, cdb3, res(63));
    end
    push(4'b1001, 8);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(8), res(11), 38'b0}) begin
      n_err++; $display("FAIL oversub_ptr: got %h %h %h expected %h %h 0", cdb1, cdb2, cdb3, res(8), res(11));
    end
  endtask

  task automatic test_fairness;
    int          order [0:7][0:2];
    int          bn [4];
    int          sn [4];
    int          seen [4];
    int          r;
    logic [3:0]  exp_rdy;
    logic [3:0]  rdy;
    logic [37:0] got [3];
    order = '{'{0,1,2}, '{3,0,1}, '{2,3,0}, '{1,2,3},
              '{0,1,2}, '{3,0,1}, '{2,3,0}, '{1,2,3}};
    for (int i = 0; i < 4; i++) begin
      bn[i] = 0; sn[i] = 0; seen[i] = 0;
      set_slot(i, res(8*i + 1));
    end
    req_valid = 4'b1111;
    n_vec++;
    if (req_ready !== 4'b1111) begin
      n_err++; $display("FAIL fair_ready_load: got %b expected 1111", req_ready);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      sn[i] = 1;
      set_slot(i, res(8*i + sn[i] + 1));
    end
    for (int c = 1; c <= 8; c++) begin
      exp_rdy = '0;
      for (int k = 0; k < 3; k++) exp_rdy[order[c-1][k]] = 1'b1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL fair_ready c%0d: got %b expected %b", c, req_ready, exp_rdy);
      end
      rdy = req_ready;
      tick();
      got[0] = cdb1; got[1] = cdb2; got[2] = cdb3;
      for (int k = 0; k < 3; k++) begin
        r = order[c-1][k];
        n_vec++;
        if (got[k] !== res(8*r + bn[r] + 1)) begin
          n_err++; $display("FAIL fair_cdb c%0d bus%0d: got %h expected %h", c, k + 1, got[k], res(8*r + bn[r] + 1));
        end
        bn[r]++;
        r = (int'(got[k][37:32]) - 1) / 8;
        if (r >= 0 && r < 4) seen[r]++;
      end
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          sn[i]++;
          set_slot(i, res(8*i + sn[i] + 1));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (seen[i] !== 6) begin
        n_err++; $display("FAIL fair_count req%0d: got %0d broadcasts expected 6", i, seen[i]);
      end
    end
    req_valid = '0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL fair_flush: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
  endtask

  task automatic test_kill;
    push(4'b0010, 30);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(31), 76'b0}) begin
      n_err++; $display("FAIL kill_setup: got %h %h %h expected %h 0 0", cdb1, cdb2, cdb3, res(31));
    end
    push(4'b1001, 32);
    set_slot(1, res(37));
    req_valid = 4'b0010;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    req_valid = '0;
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL kill_cdb: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
    n_vec++;
    if (req_ready !== 4'b1111) begin
      n_err++; $display("FAIL kill_ready: got %b expected 1111", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({cdb1, cdb2, cdb3} !== 114'b0) begin
        n_err++; $display("FAIL kill_ghost c%0d: got %h %h %h expected all zero", c, cdb1, cdb2, cdb3);
      end
    end
    push(4'b1001, 40);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(43), res(40), 38'b0}) begin
      n_err++; $display("FAIL kill_ptr_kept: got %h %h %h expected %h %h 0", cdb1, cdb2, cdb3, res(43), res(40));
    end
  endtask

  task automatic test_backpressure;
    push(4'b0010, 16);
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(17), 76'b0}) begin
      n_err++; $display("FAIL bp_setup: got %h %h %h expected %h 0 0", cdb1, cdb2, cdb3, res(17));
    end
    push(4'b1111, 20);
    set_slot(1, res(45));
    req_valid = 4'b0010;
    n_vec++;
    if (req_ready !== 4'b1101) begin
      n_err++; $display("FAIL bp_ready_low: got %b expected 1101", req_ready);
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(22), res(23), res(20)}) begin
      n_err++; $display("FAIL bp_first: got %h %h %h expected %h %h %h", cdb1, cdb2, cdb3, res(22), res(23), res(20));
    end
    n_vec++;
    if (req_ready !== 4'b1111) begin
      n_err++; $display("FAIL bp_ready_grant: got %b expected 1111", req_ready);
    end
    tick();
    req_valid = '0;
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(21), 76'b0}) begin
      n_err++; $display("FAIL bp_old: got %h %h %h expected %h 0 0", cdb1, cdb2, cdb3, res(21));
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== {res(45), 76'b0}) begin
      n_err++; $display("FAIL bp_new: got %h %h %h expected %h 0 0", cdb1, cdb2, cdb3, res(45));
    end
    tick();
    n_vec++;
    if ({cdb1, cdb2, cdb3} !== 114'b0) begin
      n_err++; $display("FAIL bp_idle: got %h %h %h expected all zero", cdb1, cdb2, cdb3);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    kill      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    #2;
    test_reset();
    test_single();
    test_oversub();
    test_fairness();
    test_kill();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire
